// File: rtl/unit_clause_scanner.sv
// unit_clause_scanner: walks the clause table one clause per cycle, classifies
// each considered clause against the current variable assignment, and offers
// every unit implication over a valid/ready handshake. A falsified clause stops
// the walk and is reported. At the end of a walk, all_sat reports whether every
// considered clause was already satisfied.
`timescale 1ns/1ps

module unit_clause_scanner #(
  parameter int WIDTH        = 9,
  parameter int MAX_CLAUSES  = 1024,
  parameter int MAX_LITERALS = 256,
  localparam int IDX_W       = $clog2(MAX_CLAUSES)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [MAX_LITERALS-1:0]            literal_assigned,
  input  logic [MAX_LITERALS-1:0]            literal_bool,
  input  logic [MAX_CLAUSES*3*WIDTH-1:0]     CNF_CLAUSE_in_packed,
  input  logic [MAX_CLAUSES-1:0]             clause_active_in,
  input  logic [MAX_CLAUSES-1:0]             clause_valid_in,
  input  logic                               imp_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               imp_valid,
  output logic [WIDTH-1:0]                   imp_literal,
  output logic [IDX_W-1:0]                   imp_clause_idx,
  output logic                               conflict,
  output logic [IDX_W-1:0]                   conflict_clause_idx,
  output logic                               all_sat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CLAUSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {LIT_EMPTY, LIT_TRUE, LIT_FALSE, LIT_OPEN} lit_state_t;
  typedef enum logic [2:0] {CL_SKIP, CL_SAT, CL_CONFLICT, CL_UNIT, CL_OPEN} clause_class_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  sat_q;
  logic                  at_last;

  logic [3*WIDTH-1:0]    clause_words [MAX_CLAUSES];
  logic [3*WIDTH-1:0]    cur_word;
  logic [WIDTH-1:0]      slot;
  lit_state_t            slot_state;
  logic [1:0]            n_open;
  logic                  any_true;
  logic [WIDTH-1:0]      unit_lit;
  clause_class_t         cls;

  // Reshape the flat clause bus into one word of three slots per clause.
  for (genvar c = 0; c < MAX_CLAUSES; c++) begin : g_words
    assign clause_words[c] = CNF_CLAUSE_in_packed[c*3*WIDTH +: 3*WIDTH];
  end

  // A literal's variable is its two's-complement magnitude; a variable outside
  // the assignment vectors selects no bit and so reads as unassigned (OPEN).
  function automatic lit_state_t eval_lit(input logic [WIDTH-1:0]        lit,
                                          input logic [MAX_LITERALS-1:0] asg,
                                          input logic [MAX_LITERALS-1:0] val);
    logic [WIDTH-1:0]        mag;
    logic [MAX_LITERALS-1:0] sel;
    logic                    asg_bit;
    logic                    val_bit;
    if (lit == '0) return LIT_EMPTY;
    mag     = lit[WIDTH-1] ? -lit : lit;
    sel     = '0;
    sel[0]  = 1'b1;
    sel     = sel << mag;
    asg_bit = |(asg & sel);
    val_bit = |(val & sel);
    if (!asg_bit) return LIT_OPEN;
    return (val_bit == ~lit[WIDTH-1]) ? LIT_TRUE : LIT_FALSE;
  endfunction

  assign at_last   = (idx_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign imp_valid = (state_q == S_EMIT);

  // Classify the clause currently addressed by idx.
  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cur_word   = clause_words[idx_q];
    slot       = '0;
    slot_state = LIT_EMPTY;
    n_open     = '0;
    any_true   = 1'b0;
    unit_lit   = '0;
    cls        = CL_SKIP;
    for (int s = 0; s < 3; s++) begin
      slot       = cur_word[s*WIDTH +: WIDTH];
      slot_state = eval_lit(slot, literal_assigned, literal_bool);
      if (slot_state == LIT_TRUE) any_true = 1'b1;
      if (slot_state == LIT_OPEN) begin
        n_open   = n_open + 2'd1;
        unit_lit = slot;
      end
    end
    if (clause_valid_in[idx_q] && clause_active_in[idx_q]) begin
      if (any_true)            cls = CL_SAT;
      else if (n_open == 2'd0) cls = CL_CONFLICT;
      else if (n_open == 2'd1) cls = CL_UNIT;
      else                     cls = CL_OPEN;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (cls == CL_CONFLICT)  state_d = S_DONE;
        else if (cls == CL_UNIT) state_d = S_EMIT;
        else if (at_last)        state_d = S_DONE;
      end
      S_EMIT: if (imp_ready) state_d = at_last ? S_DONE : S_SCAN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan index, sat flag and the latched result/implication registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q               <= '0;
      sat_q               <= 1'b0;
      done                <= 1'b0;
      all_sat             <= 1'b0;
      conflict            <= 1'b0;
      conflict_clause_idx <= '0;
      imp_literal         <= '0;
      imp_clause_idx      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q               <= '0;
            sat_q               <= 1'b1;
            all_sat             <= 1'b0;
            conflict            <= 1'b0;
            conflict_clause_idx <= '0;
          end
        end
        S_SCAN: begin
          if (cls == CL_CONFLICT) begin
            conflict            <= 1'b1;
            conflict_clause_idx <= idx_q;
          end else if (cls == CL_UNIT) begin
            imp_literal    <= unit_lit;
            imp_clause_idx <= idx_q;
            sat_q          <= 1'b0;
          end else begin
            if (cls == CL_OPEN) sat_q <= 1'b0;
            if (!at_last)       idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_EMIT: begin
          if (imp_ready && !at_last) idx_q <= idx_q + IDX_W'(1);
        end
        S_DONE: begin
          done    <= 1'b1;
          all_sat <= sat_q & ~conflict;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_clause_scanner.sv
// Self-checking bench for unit_clause_scanner with 4 clauses of 9-bit literals.
// A behavioural model derives the expected implication list, conflict and
// all_sat from the clause table; a negedge compare process checks the DUT
// against it on every cycle of a scan.
`timescale 1ns/1ps

module tb_unit_clause_scanner;

  localparam int WIDTH = 9;
  localparam int NCL   = 4;
  localparam int NLIT  = 16;
  localparam int IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    imp_ready = 1'b0;
  logic [NLIT-1:0]         literal_assigned = '0;
  logic [NLIT-1:0]         literal_bool = '0;
  logic [NCL*3*WIDTH-1:0]  cnf = '0;
  logic [NCL-1:0]          clause_active_in = '0;
  logic [NCL-1:0]          clause_valid_in = '0;
  logic                    busy, done, imp_valid, conflict, all_sat;
  logic [WIDTH-1:0]        imp_literal;
  logic [IDX_W-1:0]        imp_clause_idx, conflict_clause_idx;

  unit_clause_scanner #(.WIDTH(WIDTH), .MAX_CLAUSES(NCL), .MAX_LITERALS(NLIT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .literal_assigned    (literal_assigned),
    .literal_bool        (literal_bool),
    .CNF_CLAUSE_in_packed(cnf),
    .clause_active_in    (clause_active_in),
    .clause_valid_in     (clause_valid_in),
    .imp_ready           (imp_ready),
    .busy                (busy),
    .done                (done),
    .imp_valid           (imp_valid),
    .imp_literal         (imp_literal),
    .imp_clause_idx      (imp_clause_idx),
    .conflict            (conflict),
    .conflict_clause_idx (conflict_clause_idx),
    .all_sat             (all_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scenario: literals as signed ints, assignment and clause flags as bits.
  int lits [NCL][3];
  bit asg [NLIT];
  bit val [NLIT];
  bit cvalid [NCL];
  bit cactive [NCL];

  typedef struct {
    int lit;
    int idx;
  } imp_t;

  imp_t exp_imps [$];
  bit   exp_conflict;
  int   exp_cidx;
  bit   exp_all_sat;
  int   exp_scanned;

  function automatic logic [WIDTH-1:0] lit_bits(input int l);
    return WIDTH'(l);
  endfunction

  // Behavioural model: walk the clauses in order and apply the clause rules.
  function automatic void model();
    bit   sat;
    int   ntrue, nopen, open_lit, v, l;
    imp_t e;
    exp_imps.delete();
    exp_conflict = 0;
    exp_cidx     = 0;
    exp_scanned  = 0;
    sat          = 1;
    for (int c = 0; c < NCL; c++) begin
      exp_scanned++;
      if (!(cvalid[c] && cactive[c])) continue;
      ntrue = 0;
      nopen = 0;
      open_lit = 0;
      for (int s = 0; s < 3; s++) begin
        l = lits[c][s];
        if (l == 0) continue;
        v = (l < 0) ? -l : l;
        if (v >= NLIT || !asg[v]) begin
          nopen++;
          open_lit = l;
        end else if ((l > 0) == val[v]) begin
          ntrue++;
        end
      end
      if (ntrue > 0) continue;
      if (nopen == 0) begin
        exp_conflict = 1;
        exp_cidx     = c;
        break;
      end
      sat = 0;
      if (nopen == 1) begin
        e.lit = open_lit;
        e.idx = c;
        exp_imps.push_back(e);
      end
    end
    exp_all_sat = sat && !exp_conflict;
  endfunction

  task automatic clear_scenario();
    for (int c = 0; c < NCL; c++) begin
      for (int s = 0; s < 3; s++) lits[c][s] = 0;
      cvalid[c]  = 0;
      cactive[c] = 1;
    end
    for (int v = 0; v < NLIT; v++) begin
      asg[v] = 0;
      val[v] = 0;
    end
  endtask

  task automatic apply();
    for (int c = 0; c < NCL; c++) begin
      for (int s = 0; s < 3; s++) cnf[(c*3+s)*WIDTH +: WIDTH] = lit_bits(lits[c][s]);
      clause_valid_in[c]  = cvalid[c];
      clause_active_in[c] = cactive[c];
    end
    for (int v = 0; v < NLIT; v++) begin
      literal_assigned[v] = asg[v];
      literal_bool[v]     = val[v];
    end
  endtask

  // Compare-process state.
  int               cyc = 0;
  bit               run_active = 0;
  int               start_cyc = 0;
  int               emit_cycles = 0;
  int               done_count = 0;
  int               done_lat = 0;
  int               acc_count = 0;
  logic [WIDTH-1:0] acc_lit = '0;
  logic [IDX_W-1:0] acc_idx = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Compare the DUT against the model on every cycle of an active scan.
  always @(negedge clk) begin
    if (done) done_count = done_count + 1;
    if (run_active) begin
      if (imp_valid) begin
        emit_cycles = emit_cycles + 1;
        if (exp_imps.size() == 0) begin
          check("imp_unexpected", 32'(imp_literal), 32'(0));
        end else begin
          check("imp_literal", 32'(imp_literal), 32'(lit_bits(exp_imps[0].lit)));
          check("imp_clause_idx", 32'(imp_clause_idx), 32'(exp_imps[0].idx));
          if (imp_ready) begin
            acc_lit   = imp_literal;
            acc_idx   = imp_clause_idx;
            acc_count = acc_count + 1;
            void'(exp_imps.pop_front());
          end
        end
      end
      if (done) begin
        done_lat = cyc - start_cyc;
        check("conflict", 32'(conflict), 32'(exp_conflict));
        check("conflict_clause_idx", 32'(conflict_clause_idx), 32'(exp_conflict ? exp_cidx : 0));
        check("all_sat", 32'(all_sat), 32'(exp_all_sat));
        check("imp_missing", 32'(exp_imps.size()), 32'(0));
        check("done_latency", 32'(done_lat), 32'(exp_scanned + emit_cycles + 1));
        run_active = 0;
      end
    end
  end

  // Run one scan. hold >= 0: imp_ready low for hold EMIT cycles then high;
  // hold < 0: random imp_ready. mid_start: loop cycle to re-pulse start (-1 none).
  task automatic run_scan(input int hold, input int mid_start);
    int ready_hold;
    model();
    apply();
    emit_cycles = 0;
    done_count  = 0;
    acc_count   = 0;
    done_lat    = 0;
    ready_hold  = hold;
    @(posedge clk); #1;
    start     = 1'b1;
    imp_ready = 1'b0;
    @(posedge clk); #1;
    start      = 1'b0;
    start_cyc  = cyc;
    run_active = 1;
    for (int i = 0; i < 300 && run_active; i++) begin
      if (hold >= 0) begin
        if (imp_valid) begin
          if (ready_hold > 0) begin
            imp_ready  = 1'b0;
            ready_hold = ready_hold - 1;
          end else begin
            imp_ready = 1'b1;
          end
        end else begin
          imp_ready = 1'b0;
        end
      end else begin
        imp_ready = 1'($urandom_range(0, 1));
      end
      start = (i == mid_start);
      @(posedge clk); #1;
    end
    start     = 1'b0;
    imp_ready = 1'b0;
    if (run_active) begin
      check("done_timeout", 32'(0), 32'(1));
      run_active = 0;
    end else begin
      check("done_one_cycle", 32'(done), 32'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_imp_valid"}, 32'(imp_valid), 32'(0));
    check({tag, "_imp_literal"}, 32'(imp_literal), 32'(0));
    check({tag, "_imp_clause_idx"}, 32'(imp_clause_idx), 32'(0));
    check({tag, "_conflict"}, 32'(conflict), 32'(0));
    check({tag, "_conflict_idx"}, 32'(conflict_clause_idx), 32'(0));
    check({tag, "_all_sat"}, 32'(all_sat), 32'(0));
  endtask

  // Start a scan, assert reset mid-cycle after n_edges further clock edges.
  task automatic reset_during(input int n_edges, input bit in_emit);
    apply();
    @(posedge clk); #1 start = 1'b1;
    imp_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (n_edges) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'(1));
    if (in_emit) check("pre_reset_imp_valid", 32'(imp_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero(in_emit ? "rst_emit" : "rst_scan");
    @(posedge clk); #1 rst_n = 1'b1;
    imp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_busy", 32'(busy), 32'(0));
    check("post_reset_imp_valid", 32'(imp_valid), 32'(0));
    imp_ready = 1'b0;
  endtask

  task automatic setup_all_true();
    clear_scenario();
    for (int c = 0; c < NCL; c++) begin
      lits[c][0]   = c + 1;
      asg[c+1]     = 1;
      val[c+1]     = 1;
      cvalid[c]    = 1;
    end
  endtask

  task automatic setup_unit0();
    clear_scenario();
    lits[0][0] = 1;
    lits[0][1] = -2;
    lits[0][2] = 3;
    cvalid[0]  = 1;
    asg[1] = 1; val[1] = 0;
    asg[2] = 1; val[2] = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12 check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'(0));

    // Unit implication held under backpressure for 3 cycles.
    setup_unit0();
    model();
    check("m44_model_count", 32'(exp_imps.size()), 32'(1));
    if (exp_imps.size() == 1) check("m44_model_lit", 32'(exp_imps[0].lit), 32'(3));
    run_scan(3, -1);
    check("m44_accepted", 32'(acc_count), 32'(1));
    check("m44_lit", 32'(acc_lit), 32'(lit_bits(3)));
    check("m44_idx", 32'(acc_idx), 32'(0));
    check("m44_emit_cycles", 32'(emit_cycles), 32'(4));
    check("m44_all_sat", 32'(all_sat), 32'(0));

    // Conflict at clause 2 stops the scan before the clause-3 unit.
    clear_scenario();
    asg[1] = 1; val[1] = 0;
    asg[2] = 1; val[2] = 0;
    lits[0][0] = -1;
    lits[1][0] = -2; lits[1][1] = 5;
    lits[2][0] = 1;  lits[2][1] = 2;
    lits[3][0] = 1;  lits[3][1] = 4;
    for (int c = 0; c < NCL; c++) cvalid[c] = 1;
    run_scan(-1, -1);
    check("m45_conflict", 32'(conflict), 32'(1));
    check("m45_conflict_idx", 32'(conflict_clause_idx), 32'(2));
    check("m45_no_imp", 32'(emit_cycles), 32'(0));
    check("m45_latency", 32'(done_lat), 32'(4));
    check("m45_done_pulses", 32'(done_count), 32'(1));

    // Results hold after done until the next start.
    repeat (3) @(posedge clk);
    #1;
    check("hold_conflict", 32'(conflict), 32'(1));
    check("hold_conflict_idx", 32'(conflict_clause_idx), 32'(2));

    // Every clause satisfied.
    setup_all_true();
    run_scan(-1, -1);
    check("m46_latency", 32'(done_lat), 32'(5));
    check("m46_all_sat", 32'(all_sat), 32'(1));
    check("m46_no_imp", 32'(emit_cycles), 32'(0));

    // Skipped falsified clauses do not count.
    setup_all_true();
    lits[1][0] = -1;
    cvalid[1]  = 0;
    lits[3][0] = -2;
    cactive[3] = 0;
    run_scan(-1, -1);
    check("m47_conflict", 32'(conflict), 32'(0));
    check("m47_all_sat", 32'(all_sat), 32'(1));

    // Start pulsed mid-scan is ignored.
    setup_all_true();
    run_scan(-1, 1);
    repeat (8) @(posedge clk);
    #1;
    check("m48_latency", 32'(done_lat), 32'(5));
    check("m48_done_pulses", 32'(done_count), 32'(1));
    check("m48_busy", 32'(busy), 32'(0));

    // Asynchronous reset mid-SCAN and mid-EMIT.
    setup_all_true();
    reset_during(1, 1'b0);
    setup_unit0();
    reset_during(1, 1'b1);

    // Randomized scans against the model.
    for (int it = 0; it < 60; it++) begin
      clear_scenario();
      for (int c = 0; c < NCL; c++) begin
        for (int s = 0; s < 3; s++) begin
          if ($urandom_range(0, 5) == 0) lits[c][s] = 0;
          else lits[c][s] = int'($urandom_range(1, 6)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
        end
        cvalid[c]  = ($urandom_range(0, 3) != 0);
        cactive[c] = ($urandom_range(0, 3) != 0);
      end
      for (int v = 1; v <= 6; v++) begin
        asg[v] = ($urandom_range(0, 2) != 0);
        val[v] = 1'($urandom_range(0, 1));
      end
      run_scan(-1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unit_clause_scanner.md
UNIT_CLAUSE_SCANNER -- requirements
Module: unit_clause_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, the literal width: two's complement, sign bit = negated, magnitude = variable index, value 0 = empty slot.
REQ-002 The block SHALL have parameter MAX_CLAUSES, default 1024, the number of clause slots scanned.
REQ-003 The block SHALL have parameter MAX_LITERALS, default 256, the width of the variable assignment vectors.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: the single clock, rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: single-cycle request to begin a scan.
REQ-008 Port literal_assigned, input, MAX_LITERALS: per-variable assigned flag.
REQ-009 Port literal_bool, input, MAX_LITERALS: per-variable value.
REQ-010 Port CNF_CLAUSE_in_packed, input, MAX_CLAUSES*3*WIDTH: clause c, slot s at bits [(c*3+s)*WIDTH +: WIDTH].
REQ-011 Port clause_active_in, input, MAX_CLAUSES: per-clause active flag.
REQ-012 Port clause_valid_in, input, MAX_CLAUSES: per-clause valid flag.
REQ-013 Port imp_ready, input, 1: the consumer accepts an implication.
REQ-014 Port busy, output, 1: high while the scan is not IDLE.
REQ-015 Port done, output, 1: one-cycle end-of-scan pulse.
REQ-016 Port imp_valid, output, 1: implication offered to the consumer.
REQ-017 Port imp_literal, output, WIDTH: the implied literal.
REQ-018 Port imp_clause_idx, output, $clog2(MAX_CLAUSES): index of the source clause.
REQ-019 Port conflict, output, 1: a falsified clause was found.
REQ-020 Port conflict_clause_idx, output, $clog2(MAX_CLAUSES): index of the conflicting clause.
REQ-021 Port all_sat, output, 1: every considered clause was satisfied.

Function
REQ-022 Each literal slot SHALL evaluate as: empty if the literal is 0; TRUE if assigned and the value equals the non-negated polarity; FALSE if assigned and the value does not match; OPEN if unassigned. Variable index = two's complement magnitude.
REQ-023 A clause SHALL be considered only if clause_valid_in and clause_active_in are both 1; all other clauses are skipped, with no effect on any output or flag.
REQ-024 A considered clause with any TRUE slot SHALL be satisfied.
REQ-025 A considered clause with no TRUE slot and 0 OPEN slots SHALL be a conflict.
REQ-026 A considered clause with no TRUE slot and exactly 1 OPEN slot SHALL be a unit; its implied literal is that OPEN slot's literal.
REQ-027 The FSM SHALL have states IDLE, SCAN, EMIT, DONE.
REQ-028 In IDLE, start SHALL clear idx, conflict and the sat flag (set to 1), then move to SCAN; start in any other state SHALL be ignored.
REQ-029 In SCAN, exactly one clause (idx) SHALL be evaluated per cycle.
REQ-030 In SCAN: on conflict, latch conflict=1 and conflict_clause_idx=idx, then go to DONE with no further clauses scanned.
REQ-031 In SCAN: on unit, latch the literal and idx, clear the sat flag, then go to EMIT.
REQ-032 In SCAN, an OPEN clause (2 or more OPEN slots, none TRUE) SHALL clear the sat flag.
REQ-033 In SCAN: if idx = MAX_CLAUSES-1, go to DONE; otherwise increment idx.
REQ-034 In EMIT, imp_valid SHALL be 1, and imp_literal and imp_clause_idx SHALL be stable until imp_valid&&imp_ready.
REQ-035 On acceptance in EMIT: if idx = MAX_CLAUSES-1, go to DONE, else idx+1 and return to SCAN; imp_valid SHALL be 0 the next cycle.
REQ-036 In DONE, done=1 for one cycle and all_sat SHALL be driven to the sat flag AND NOT conflict; then return to IDLE.
REQ-037 conflict, conflict_clause_idx and all_sat SHALL hold after DONE until the next accepted start.
REQ-038 Latency with no units: done SHALL assert MAX_CLAUSES+1 cycles after the start edge.
REQ-039 Duplicate implications from different clauses SHALL each be emitted; no deduplication.
REQ-040 All inputs except start and imp_ready SHALL be held stable by the upstream stage while busy=1; behaviour otherwise is undefined.

Reset
REQ-041 rst_n=0 SHALL asynchronously force IDLE and drive every output to 0 (busy, done, imp_valid, imp_literal, imp_clause_idx, conflict, conflict_clause_idx, all_sat); idx=0.
REQ-042 Reset asserted mid-SCAN or mid-EMIT SHALL drop imp_valid in the same cycle without waiting for a clock edge; no implication SHALL be emitted after release until a new start.

Verification (bench MAX_CLAUSES=4, WIDTH=9)
REQ-043 Reset check: rst_n low during SCAN -> all outputs 0 immediately, busy=0 after release.
REQ-044 Unit with backpressure: clause0=(1,-2,3), v1=0 assigned, v2=1 assigned, v3 unassigned; imp_ready=0 for 3 cycles -> imp_valid=1, imp_literal=3, imp_clause_idx=0, both stable for 3 cycles; accepted on the 4th cycle; all_sat=0 at done.
REQ-045 Conflict stops the scan: clause2=(1,2,0), v1=v2=0 assigned; clause3 a unit -> conflict=1, conflict_clause_idx=2, done pulses, and no implication from clause3.
REQ-046 All satisfied: each of the 4 clauses contains a TRUE literal -> done 5 cycles after start, all_sat=1, imp_valid never 1.
REQ-047 Skipped clause: clause1 all-FALSE with clause_valid_in[1]=0, clause3 all-FALSE with clause_active_in[3]=0 -> conflict=0.
REQ-048 Start ignored while busy: start pulsed mid-SCAN -> the scan completes unchanged, with a single done pulse.
